// File: rtl/esc_spi_pdi_master.sv
// SPI master for an EtherCAT slave controller PDI: one register read or write per host request.
// Latency: acceptance to rsp_valid = 1 + CS_SETUP + 16*CLK_DIV*bytes + CS_HOLD cycles; bad lengths answer next cycle.
// Backpressure: req_ready only in IDLE with EEPROM loaded; rsp_valid is a one-cycle pulse with no stall.
//
// Ports:
//   clk_clk, reset_reset                 clock and synchronous active-high reset
//   req_valid/req_ready                  request handshake; req_write, req_addr[12:0], req_len[2:0], req_wdata[31:0]
//   rsp_valid, rsp_rdata[31:0], rsp_err  completion pulse, read data (byte 0 in [7:0]), illegal-length flag
//   esc_spi_SCLK/MOSI/MISO/SS_n          SPI mode 3 bus to the ESC
//   esc_eepdone_input_export             asynchronous EEPROM-loaded flag (gates acceptance)
//   esc_spi_sint_export, esc_irq         asynchronous active-low interrupt in, synchronised active-high out
module esc_spi_pdi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [12:0] req_addr,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        esc_spi_SCLK,
  output logic        esc_spi_MOSI,
  input  logic        esc_spi_MISO,
  output logic        esc_spi_SS_n,
  input  logic        esc_eepdone_input_export,
  input  logic        esc_spi_sint_export,
  output logic        esc_irq
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(IDLE_GAP - 1);

  // Frame byte idx of the transaction: address/command header, then data or read filler.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic wr,
                                            input logic [12:0] a, input logic [2:0] len,
                                            input logic [31:0] wd);
    logic [1:0] k;
    k = 2'(idx - 3'd2);
    if (idx == 3'd0)                   frame_byte = a[12:5];
    else if (idx == 3'd1)              frame_byte = {a[4:0], (wr ? 3'b100 : 3'b011)};
    else if (wr)                       frame_byte = wd[{k, 3'b000} +: 8];
    else if (idx == 3'd2)              frame_byte = 8'hFF;              // wait-state byte
    else if (idx == 3'(len + 3'd2))    frame_byte = 8'hFF;              // last read byte ends the access
    else                               frame_byte = 8'h00;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;          // 0 = MSB of the current byte
  logic [2:0]  last_byte_q, last_byte_d;
  logic        wr_q, wr_d;
  logic [12:0] addr_q, addr_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rx_q, rx_d;
  logic        sclk_q, sclk_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        eep_meta_q, eep_meta_d, eep_sync_q, eep_sync_d;
  logic        sint_meta_q, sint_meta_d, sint_sync_q, sint_sync_d;

  logic [2:0]  nxt_byte, nxt_bit;
  logic [7:0]  nxt_frame_byte;
  logic [4:0]  rx_bit;
  logic        last_bit;

  assign req_ready    = (state_q == ST_IDLE) && eep_sync_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign esc_spi_SCLK = sclk_q;
  assign esc_spi_MOSI = mosi_q;
  assign esc_spi_SS_n = ss_n_q;
  assign esc_irq      = ~sint_sync_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    last_byte_d = last_byte_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    sclk_d      = sclk_q;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    eep_meta_d  = esc_eepdone_input_export;
    eep_sync_d  = eep_meta_q;
    sint_meta_d = esc_spi_sint_export;
    sint_sync_d = sint_meta_q;

    nxt_bit        = bit_idx_q + 3'd1;
    nxt_byte       = (bit_idx_q == 3'd7) ? byte_idx_q + 3'd1 : byte_idx_q;
    nxt_frame_byte = frame_byte(nxt_byte, wr_q, addr_q, len_q, wdata_q);
    rx_bit         = {2'(byte_idx_q - 3'd3), ~bit_idx_q};
    last_bit       = (byte_idx_q == last_byte_q) && (bit_idx_q == 3'd7);

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          len_d   = req_len;
          wdata_d = req_wdata;
          if (req_len >= 3'd1 && req_len <= 3'd4) begin
            state_d     = ST_SETUP;
            ss_n_d      = 1'b0;
            mosi_d      = req_addr[12];        // first bit presented together with SS_n
            cnt_d       = '0;
            byte_idx_d  = '0;
            bit_idx_d   = '0;
            last_byte_d = req_write ? req_len + 3'd1 : req_len + 3'd2;
            rx_d        = '0;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        // First cycle of the high phase is the MISO sample point; header and wait bytes are dropped.
        if (sclk_q && cnt_q == 16'd0 && !wr_q && byte_idx_q >= 3'd3)
          rx_d[rx_bit] = esc_spi_MISO;
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (last_bit) begin
            state_d = ST_HOLD;                 // SCLK parks high
          end else begin
            sclk_d     = 1'b0;
            byte_idx_d = nxt_byte;
            bit_idx_d  = nxt_bit;
            mosi_d     = nxt_frame_byte[~nxt_bit];
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d     = ST_GAP;
          ss_n_d      = 1'b1;
          mosi_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_q;                  // stays zero for writes
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= ST_GAP;
      cnt_q       <= '0;
      byte_idx_q  <= '0;
      bit_idx_q   <= '0;
      last_byte_q <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      rx_q        <= '0;
      sclk_q      <= 1'b1;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      eep_meta_q  <= 1'b0;
      eep_sync_q  <= 1'b0;
      sint_meta_q <= 1'b1;                     // inactive level, so esc_irq reads 0
      sint_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      last_byte_q <= last_byte_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      eep_meta_q  <= eep_meta_d;
      eep_sync_q  <= eep_sync_d;
      sint_meta_q <= sint_meta_d;
      sint_sync_q <= sint_sync_d;
    end
  end

endmodule

// File: tb/tb_esc_spi_pdi_master.sv
// Self-checking bench for esc_spi_pdi_master with an ESC bus model and a byte-level reference.
module tb_esc_spi_pdi_master;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int IDLE_GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [12:0] req_addr = '0;
  logic [2:0]  req_len = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, sclk, mosi, ss_n, irq;
  logic [31:0] rsp_rdata;
  logic        miso = 1'b1;
  logic        eep = 1'b1;
  logic        sint = 1'b1;

  int checks = 0;
  int failures = 0;

  esc_spi_pdi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .IDLE_GAP(IDLE_GAP)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .esc_spi_SCLK(sclk), .esc_spi_MOSI(mosi), .esc_spi_MISO(miso), .esc_spi_SS_n(ss_n),
    .esc_eepdone_input_export(eep), .esc_spi_sint_export(sint), .esc_irq(irq)
  );

  always #5 clk = ~clk;

  // ESC model: records MOSI at SCLK rising, shifts MISO out at SCLK falling, polices MOSI stability.
  logic prev_sclk = 1'b1, prev_ss = 1'b1, prev_mosi = 1'b1;
  int   fall_cnt = 0;
  int   mosi_viol = 0;
  logic mon_bits[$];
  logic miso_bits [0:63];

  always @(negedge clk) begin
    if (!ss_n && !prev_ss && mosi !== prev_mosi && !(prev_sclk && !sclk)) mosi_viol++;
    if (!ss_n && sclk && !prev_sclk) mon_bits.push_back(mosi);
    if (ss_n) fall_cnt = 0;
    else if (prev_sclk && !sclk && fall_cnt < 64) begin
      miso = miso_bits[fall_cnt];
      fall_cnt++;
    end
    prev_sclk = sclk;
    prev_ss   = ss_n;
    prev_mosi = mosi;
  end

  task automatic run_txn(input logic wr, input logic [12:0] addr, input logic [2:0] len,
                         input logic [31:0] wdata, input logic [31:0] mdata,
                         input string tag, input bit drop_eep);
    int nb, lat_exp, cyc, start, viol0, waited, a, bi;
    logic [7:0]  exp_b[$];
    logic [31:0] exp_rd;
    logic [7:0]  got;
    bit          ok;
    a  = int'(addr);
    nb = wr ? int'(len) + 2 : int'(len) + 3;
    exp_b.push_back(8'(a / 32));
    exp_b.push_back(8'((a % 32) * 8 + (wr ? 4 : 3)));
    if (wr) for (int i = 0; i < int'(len); i++) exp_b.push_back(8'(wdata >> (8 * i)));
    else begin
      exp_b.push_back(8'hFF);
      for (int i = 0; i < int'(len); i++) exp_b.push_back((i == int'(len) - 1) ? 8'hFF : 8'h00);
    end
    exp_rd = '0;
    if (!wr) for (int i = 0; i < int'(len); i++) exp_rd = exp_rd | (mdata & (32'hFF << (8 * i)));
    for (int i = 0; i < nb * 8; i++) begin
      bi = i / 8;
      if (!wr && bi >= 3) miso_bits[i] = mdata[8 * (bi - 3) + 7 - (i % 8)];
      else miso_bits[i] = 1'($urandom);
    end
    lat_exp = 1 + CS_SETUP + 16 * CLK_DIV * nb + CS_HOLD;

    waited = 0;
    while (req_ready !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_timeout got=%b want=1", tag, req_ready); return;
    end
    start = mon_bits.size();
    viol0 = mosi_viol;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len; req_wdata = wdata;
    @(posedge clk); @(negedge clk);
    // Scramble the request inputs: the captured copy must be used.
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 13'($urandom);
    req_len = 3'($urandom); req_wdata = $urandom;
    cyc = 1;
    checks++;
    if (ss_n !== 1'b0 || mosi !== exp_b[0][7]) begin
      failures++; $display("FAIL %s first_cycle ss_n=%b mosi=%b want ss_n=0 mosi=%b", tag, ss_n, mosi, exp_b[0][7]);
    end
    while (rsp_valid !== 1'b1 && cyc < 3000) begin
      if (drop_eep && cyc == 20) eep = 1'b0;
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc != lat_exp) begin failures++; $display("FAIL %s latency got=%0d want=%0d", tag, cyc, lat_exp); end
    checks++;
    if (rsp_err !== 1'b0) begin failures++; $display("FAIL %s rsp_err got=%b want=0", tag, rsp_err); end
    checks++;
    if (rsp_rdata !== exp_rd) begin failures++; $display("FAIL %s rdata got=%h want=%h", tag, rsp_rdata, exp_rd); end
    checks++;
    if (mon_bits.size() - start != nb * 8) begin
      failures++; $display("FAIL %s sclk_rises got=%0d want=%0d", tag, mon_bits.size() - start, nb * 8);
    end else begin
      ok = 1'b1;
      for (int j = 0; j < nb; j++) begin
        got = '0;
        for (int b = 0; b < 8; b++) got = {got[6:0], mon_bits[start + j * 8 + b]};
        if (ok && got !== exp_b[j]) begin
          ok = 1'b0; $display("FAIL %s mosi_byte%0d got=%h want=%h", tag, j, got, exp_b[j]);
        end
      end
      if (!ok) failures++;
    end
    checks++;
    if (mosi_viol != viol0) begin failures++; $display("FAIL %s mosi_stability got=%0d want=0 changes", tag, mosi_viol - viol0); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== exp_rd) begin
      failures++; $display("FAIL %s pulse_hold valid=%b rdata=%h want valid=0 rdata=%h", tag, rsp_valid, rsp_rdata, exp_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ss_n !== 1'b1)      begin failures++; $display("FAIL reset ss_n got=%b want=1", ss_n); end
    checks++; if (sclk !== 1'b1)      begin failures++; $display("FAIL reset sclk got=%b want=1", sclk); end
    checks++; if (mosi !== 1'b1)      begin failures++; $display("FAIL reset mosi got=%b want=1", mosi); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset ready got=%b want=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL reset rsp valid=%b err=%b want 0 0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset rdata got=%h want=0", rsp_rdata); end
    checks++; if (irq !== 1'b0)       begin failures++; $display("FAIL reset irq got=%b want=0", irq); end
    rst = 1'b0;
  endtask

  task automatic test_irq();
    @(negedge clk); sint = 1'b0;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b want=0", irq); end
    @(negedge clk); @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_assert got=%b want=1", irq); end
    sint = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_release got=%b want=0", irq); end
  endtask

  task automatic test_directed();
    run_txn(1'b1, 13'h0120, 3'd2, 32'h0000_0008, 32'h0, "write_0120", 1'b0);
    run_txn(1'b0, 13'h0E00, 3'd4, 32'h0, 32'h4433_2211, "read_0E00", 1'b0);
    run_txn(1'b0, 13'h1FFF, 3'd1, 32'h0, $urandom, "read_1FFF", 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      run_txn(1'($urandom), 13'($urandom), 3'($urandom_range(1, 4)), $urandom, $urandom, "random", 1'b0);
  endtask

  task automatic test_errors();
    logic [2:0] lens [0:2];
    int waited;
    bit ss_fell;
    lens[0] = 3'd0; lens[1] = 3'd6; lens[2] = 3'($urandom_range(5, 7));
    for (int n = 0; n < 3; n++) begin
      waited = 0;
      while (req_ready !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
      req_valid = 1'b1; req_write = 1'($urandom); req_addr = 13'($urandom);
      req_len = lens[n]; req_wdata = $urandom;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
        failures++; $display("FAIL err_len%0d rsp valid=%b err=%b rdata=%h want 1 1 0", lens[n], rsp_valid, rsp_err, rsp_rdata);
      end
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL err_len%0d back_to_idle ready=%b want=1", lens[n], req_ready); end
      ss_fell = (ss_n !== 1'b1);
      repeat (5) begin @(negedge clk); if (ss_n !== 1'b1 || rsp_valid !== 1'b0) ss_fell = 1'b1; end
      checks++;
      if (ss_fell) begin failures++; $display("FAIL err_len%0d quiet_bus ss_n=%b valid=%b want 1 0", lens[n], ss_n, rsp_valid); end
    end
  endtask

  task automatic test_eepdone();
    bit seen;
    @(negedge clk); eep = 1'b0;
    repeat (4) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_len = 3'd0; req_addr = 13'($urandom);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (req_ready !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL eep_low ready got=1 want=0"); end
    eep = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL eep_sync_early ready=%b want=0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL eep_sync_third ready=%b want=1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      failures++; $display("FAIL eep_accept rsp valid=%b err=%b want 1 1", rsp_valid, rsp_err);
    end
  endtask

  task automatic test_eep_drop();
    run_txn(1'b0, 13'($urandom), 3'd2, 32'h0, $urandom, "eep_drop", 1'b1);
    repeat (IDLE_GAP + 4) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL eep_drop_block ready=%b want=0", req_ready); end
    eep = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL eep_drop_recover ready=%b want=1", req_ready); end
  endtask

  task automatic test_reset_mid();
    int waited, start, k;
    bit pulse;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
    for (int i = 0; i < 64; i++) miso_bits[i] = 1'($urandom);
    req_valid = 1'b1; req_write = 1'b0; req_len = 3'd4; req_addr = 13'($urandom);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    start = mon_bits.size();
    waited = 0;
    while (mon_bits.size() - start < 10 && waited < 2000) begin @(negedge clk); waited++; end
    checks++;
    if (mon_bits.size() - start < 10) begin failures++; $display("FAIL rst_mid reach_byte1 rises=%0d want>=10", mon_bits.size() - start); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ss_n !== 1'b1 || sclk !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid abort ss_n=%b sclk=%b valid=%b want 1 1 0", ss_n, sclk, rsp_valid);
    end
    pulse = 1'b0;
    repeat (2) begin @(negedge clk); if (rsp_valid !== 1'b0) pulse = 1'b1; end
    rst = 1'b0;
    k = 0;
    while (req_ready !== 1'b1 && k < 100) begin
      @(negedge clk); k++;
      if (rsp_valid !== 1'b0) pulse = 1'b1;
    end
    checks++;
    if (pulse) begin failures++; $display("FAIL rst_mid no_rsp got=1 want=0"); end
    checks++;
    if (req_ready !== 1'b1 || k < IDLE_GAP) begin
      failures++; $display("FAIL rst_mid gap cycles=%0d ready=%b want>=%0d ready=1", k, req_ready, IDLE_GAP);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) miso_bits[i] = 1'b0;
    test_reset();
    test_irq();
    test_directed();
    test_errors();
    test_random();
    test_eepdone();
    test_eep_drop();
    test_reset_mid();
    run_txn(1'b1, 13'($urandom), 3'd4, $urandom, 32'h0, "after_reset", 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
